// File: rtl/censor_pkg.sv
// Shared constants, state encoding and result payload for the word hash sequencer.
package censor_pkg;

    localparam int unsigned MAX_LEN_DEF = 32;
    localparam int unsigned HASH_W_DEF  = 32;
    localparam int unsigned WORD_W      = 8 * MAX_LEN_DEF;
    localparam int unsigned LEN_W       = 6;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        COLLECT,
        HASH,
        EMIT
    } state_e;

    typedef struct packed {
        logic [WORD_W-1:0]     word;
        logic [HASH_W_DEF-1:0] hash;
        logic                  is_present;
        logic [LEN_W-1:0]      len;
        logic                  truncated;
    } result_t;

    function automatic logic is_delim(input logic [7:0] b);
        return (b == CH_SPACE) || (b == CH_TAB) || (b == CH_LF) || (b == CH_CR);
    endfunction

endpackage

// File: rtl/word_hash_sequencer_if.sv
// Byte stream, hash engine and result channels of the word hash sequencer.
interface word_hash_sequencer_if
    import censor_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned HASH_W  = 32,
    parameter int unsigned CNT_W   = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_data;
    logic                   in_last;

    logic                   eng_enable;
    logic                   eng_ready;
    logic [8*MAX_LEN-1:0]   eng_word;
    logic [HASH_W-1:0]      eng_hash;
    logic                   eng_is_present;

    logic                   res_valid;
    logic                   res_ready;
    logic [8*MAX_LEN-1:0]   res_word;
    logic [HASH_W-1:0]      res_hash;
    logic                   res_is_present;
    logic [LEN_W-1:0]       res_len;
    logic                   res_truncated;

    logic [CNT_W-1:0]       word_count;
    logic [CNT_W-1:0]       hit_count;

    modport slave (
        input  in_valid, in_data, in_last, eng_ready, eng_hash, eng_is_present, res_ready,
        output in_ready, eng_enable, eng_word, res_valid, res_word, res_hash,
               res_is_present, res_len, res_truncated, word_count, hit_count
    );

    modport master (
        output in_valid, in_data, in_last, eng_ready, eng_hash, eng_is_present, res_ready,
        input  in_ready, eng_enable, eng_word, res_valid, res_word, res_hash,
               res_is_present, res_len, res_truncated, word_count, hit_count
    );
endinterface

// File: rtl/word_hash_sequencer_assembler.sv
// Packs accepted characters into the word buffer and flags word boundaries.
module word_assembler
    import censor_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 accept_i,
    input  logic [7:0]           data_i,
    input  logic                 last_i,
    input  logic                 clear_i,
    output logic [8*MAX_LEN-1:0] word_o,
    output logic [LEN_W-1:0]     len_o,
    output logic                 trunc_o,
    output logic                 done_c_o
);
    localparam int unsigned WW = 8 * MAX_LEN;

    logic [WW-1:0]    wbuf_q;
    logic [LEN_W-1:0] len_q;
    logic             trunc_q;
    logic             delim_c;

    assign delim_c = is_delim(data_i);

    // A character always leaves len>0 (appended or overflowing), so in_last on it closes the word.
    assign done_c_o = accept_i && (delim_c ? (len_q != '0) : last_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wbuf_q  <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else if (accept_i && !delim_c) begin
            if (len_q < LEN_W'(MAX_LEN)) begin
                wbuf_q <= {wbuf_q[WW-9:0], data_i};
                len_q  <= len_q + LEN_W'(1);
            end else begin
                trunc_q <= 1'b1;
            end
        end
    end

    assign word_o  = wbuf_q;
    assign len_o   = len_q;
    assign trunc_o = trunc_q;

endmodule

// File: rtl/word_hash_sequencer.sv
// Tokenises a byte stream into words, hashes each via the shared engine and emits one result per word.
module word_hash_sequencer
    import censor_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned HASH_W  = HASH_W_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input logic                  clock,
    input logic                  reset,
    word_hash_sequencer_if.slave bus
);
    localparam int unsigned WORD_BITS = 8 * MAX_LEN;

    state_e               state_q;
    logic                 in_ready_q;
    logic                 eng_enable_q;
    logic                 res_valid_q;
    result_t              res_q;
    logic [CNT_W-1:0]     word_count_q;
    logic [CNT_W-1:0]     word_count_d;
    logic [CNT_W-1:0]     hit_count_q;
    logic [CNT_W-1:0]     hit_count_d;

    logic [WORD_BITS-1:0] asm_word;
    logic [LEN_W-1:0]     asm_len;
    logic                 asm_trunc;
    logic                 word_done_c;
    logic                 accept_c;
    logic                 clear_c;
    logic                 hit_c;
    logic [HASH_W-1:0]    hash_c;

    assign accept_c = bus.in_valid && in_ready_q;
    assign clear_c  = (state_q == EMIT) && res_valid_q && bus.res_ready;
    assign hash_c   = bus.eng_hash;
    assign hit_c    = bus.eng_is_present;

    word_assembler #(.MAX_LEN(MAX_LEN)) u_asm (
        .clk_i    (clock),
        .rst_i    (reset),
        .accept_i (accept_c),
        .data_i   (bus.in_data),
        .last_i   (bus.in_last),
        .clear_i  (clear_c),
        .word_o   (asm_word),
        .len_o    (asm_len),
        .trunc_o  (asm_trunc),
        .done_c_o (word_done_c)
    );

    // Saturating statistics increments.
    always_comb begin
        word_count_d = word_count_q;
        hit_count_d  = hit_count_q;
        if (word_count_q != '1) word_count_d = word_count_q + CNT_W'(1);
        if (hit_c && (hit_count_q != '1)) hit_count_d = hit_count_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= COLLECT;
            in_ready_q   <= 1'b0;
            eng_enable_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_q        <= '0;
            word_count_q <= '0;
            hit_count_q  <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (word_done_c) begin
                        state_q      <= HASH;
                        in_ready_q   <= 1'b0;
                        eng_enable_q <= 1'b1;
                    end else begin
                        in_ready_q   <= 1'b1;
                    end
                end
                HASH: begin
                    if (eng_enable_q && bus.eng_ready) begin
                        state_q      <= EMIT;
                        eng_enable_q <= 1'b0;
                        res_valid_q  <= 1'b1;
                        res_q        <= '{word: asm_word, hash: hash_c, is_present: hit_c,
                                          len: asm_len, truncated: asm_trunc};
                        word_count_q <= word_count_d;
                        hit_count_q  <= hit_count_d;
                    end
                end
                EMIT: begin
                    if (clear_c) begin
                        state_q     <= COLLECT;
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.eng_enable     = eng_enable_q;
    assign bus.eng_word       = asm_word;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_word       = res_q.word;
    assign bus.res_hash       = res_q.hash;
    assign bus.res_is_present = res_q.is_present;
    assign bus.res_len        = res_q.len;
    assign bus.res_truncated  = res_q.truncated;
    assign bus.word_count     = word_count_q;
    assign bus.hit_count      = hit_count_q;

endmodule

// File: tb/tb_word_hash_sequencer.sv
// Randomised bench for word_hash_sequencer against a word-level queue model and an engine stub.
module tb_word_hash_sequencer;
    import censor_pkg::*;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned HASH_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WW      = 8 * MAX_LEN;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    word_hash_sequencer_if #(.MAX_LEN(MAX_LEN), .HASH_W(HASH_W), .CNT_W(CNT_W)) bus_if ();

    word_hash_sequencer #(.MAX_LEN(MAX_LEN), .HASH_W(HASH_W), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: words as byte queues, results as queued records
    typedef struct {
        logic [WW-1:0] word;
        int            len;
        bit            trunc;
    } exp_t;

    byte unsigned  cur[$];
    bit            cur_trunc = 1'b0;
    exp_t          exp_res[$];
    logic [WW-1:0] exp_eng[$];
    int n_words = 0, n_results = 0, en_rises = 0;
    int m_words = 0, m_hits = 0;
    bit all_hit = 1'b0, idle_ready = 1'b0, rand_eng = 1'b0, rand_res = 1'b0;
    int eng_delay = 2, res_delay = 0;
    logic [WW-1:0] last_word;
    int last_len;
    bit last_trunc, last_present;

    function automatic logic [HASH_W-1:0] ref_hash(input logic [WW-1:0] w);
        logic [HASH_W-1:0] h = 32'h1234ABCD;
        for (int i = 0; i < 8; i++) h = {h[26:0], h[31:27]} ^ w[32*i +: 32];
        return h;
    endfunction

    function automatic bit ref_present(input logic [WW-1:0] w);
        return all_hit || (w == WW'(24'h636174)) || (w == WW'(16'h6F6B));
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_byte(input byte unsigned b, input bit last);
        bit   d = (b == 8'h20) || (b == 8'h09) || (b == 8'h0A) || (b == 8'h0D);
        exp_t e;
        if (!d) begin
            if (cur.size() < MAX_LEN) cur.push_back(b);
            else cur_trunc = 1'b1;
        end
        if ((d || last) && cur.size() > 0) begin
            e.word = '0;
            for (int i = 0; i < cur.size(); i++) e.word[8*(cur.size()-1-i) +: 8] = cur[i];
            e.len   = cur.size();
            e.trunc = cur_trunc;
            exp_res.push_back(e);
            exp_eng.push_back(e.word);
            n_words++;
            cur.delete();
            cur_trunc = 1'b0;
        end
    endtask

    task automatic send_byte(input byte unsigned b, input bit last);
        int t = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        bus_if.in_last  = last;
        while (!bus_if.in_ready && t < 1000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 1000) begin
            check("in_ready_timeout", WW'(0), WW'(1));
        end else begin
            @(posedge clock);
            model_byte(b, last);
        end
        @(negedge clock);
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_res.size() != 0 || bus_if.res_valid || !bus_if.in_ready) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        check("drain", WW'(exp_res.size()), WW'(0));
        @(negedge clock);
    endtask

    // Engine stub: replies eng_delay cycles after enable, checks word presentation
    initial begin
        bit            was_en;
        int            cnt, dly;
        logic [WW-1:0] latched;
        was_en = 1'b0; cnt = 0; dly = 0; latched = '0;
        bus_if.eng_ready = 1'b0; bus_if.eng_hash = '0; bus_if.eng_is_present = 1'b0;
        forever begin
            @(negedge clock);
            if (bus_if.eng_enable) begin
                if (!was_en) begin
                    en_rises++;
                    latched = bus_if.eng_word;
                    if (exp_eng.size() > 0) check("eng_word", bus_if.eng_word, exp_eng.pop_front());
                    else check("eng_unexpected", WW'(1), WW'(0));
                    dly = rand_eng ? int'($urandom_range(0, 4)) : eng_delay;
                    cnt = 0;
                end else begin
                    check("eng_word_stable", bus_if.eng_word, latched);
                end
                check("in_ready_hash", WW'(bus_if.in_ready), WW'(0));
                if (cnt == dly) begin
                    bus_if.eng_ready      = 1'b1;
                    bus_if.eng_hash       = ref_hash(bus_if.eng_word);
                    bus_if.eng_is_present = ref_present(bus_if.eng_word);
                end else begin
                    bus_if.eng_ready      = 1'b0;
                    bus_if.eng_hash       = 32'hDEADBEEF;
                    bus_if.eng_is_present = 1'b1;
                end
                cnt++;
                was_en = 1'b1;
            end else begin
                was_en                = 1'b0;
                bus_if.eng_ready      = idle_ready;
                bus_if.eng_hash       = 32'hDEADBEEF;
                bus_if.eng_is_present = idle_ready;
            end
        end
    end

    // Result consumer: scoreboards each result, holds res_ready low for res_delay cycles
    initial begin
        bit            seen;
        int            wait_left;
        exp_t          e;
        logic [WW-1:0] snap_word, snap_misc;
        seen = 1'b0; wait_left = 0;
        bus_if.res_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (bus_if.res_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    n_results++;
                    if (exp_res.size() > 0) begin
                        e = exp_res.pop_front();
                        m_words++;
                        if (ref_present(e.word)) m_hits++;
                        check("res_word", bus_if.res_word, e.word);
                        check("res_len", WW'(bus_if.res_len), WW'(e.len));
                        check("res_truncated", WW'(bus_if.res_truncated), WW'(e.trunc));
                        check("res_hash", WW'(bus_if.res_hash), WW'(ref_hash(e.word)));
                        check("res_is_present", WW'(bus_if.res_is_present), WW'(ref_present(e.word)));
                        check("word_count", WW'(bus_if.word_count), WW'(sat(m_words)));
                        check("hit_count", WW'(bus_if.hit_count), WW'(sat(m_hits)));
                    end else begin
                        check("res_unexpected", WW'(1), WW'(0));
                    end
                    last_word    = bus_if.res_word;
                    last_len     = int'(bus_if.res_len);
                    last_trunc   = bus_if.res_truncated;
                    last_present = bus_if.res_is_present;
                    snap_word    = bus_if.res_word;
                    snap_misc    = WW'({bus_if.res_hash, bus_if.res_is_present, bus_if.res_len,
                                        bus_if.res_truncated, bus_if.word_count, bus_if.hit_count});
                    wait_left    = rand_res ? int'($urandom_range(0, 3)) : res_delay;
                end else begin
                    check("res_word_stable", bus_if.res_word, snap_word);
                    check("res_fields_stable", WW'({bus_if.res_hash, bus_if.res_is_present, bus_if.res_len,
                          bus_if.res_truncated, bus_if.word_count, bus_if.hit_count}), snap_misc);
                end
                check("in_ready_emit", WW'(bus_if.in_ready), WW'(0));
                if (wait_left == 0) bus_if.res_ready = 1'b1;
                else begin
                    bus_if.res_ready = 1'b0;
                    wait_left--;
                end
            end else begin
                seen = 1'b0;
                bus_if.res_ready = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte unsigned dl[4];
        int           r, t, wc0, r0, p0;
        dl[0] = 8'h20; dl[1] = 8'h09; dl[2] = 8'h0A; dl[3] = 8'h0D;
        bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.in_last = 1'b0;

        // Reset values and in_ready release
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", WW'(bus_if.in_ready), WW'(0));
        check("rst_eng_enable", WW'(bus_if.eng_enable), WW'(0));
        check("rst_res_valid", WW'(bus_if.res_valid), WW'(0));
        check("rst_eng_word", bus_if.eng_word, WW'(0));
        check("rst_counts", WW'({bus_if.word_count, bus_if.hit_count}), WW'(0));
        reset = 1'b0;
        @(negedge clock);
        check("in_ready_after_reset", WW'(bus_if.in_ready), WW'(1));

        // Basic flow
        eng_delay = 2; res_delay = 0;
        send_str("hi cat", 1'b1);
        drain();
        check("basic_word_count", WW'(bus_if.word_count), WW'(2));
        check("basic_hit_count", WW'(bus_if.hit_count), WW'(1));
        check("basic_last_word", last_word, WW'(24'h636174));

        // Delimiter runs
        r0 = en_rises; p0 = n_results;
        send_str("  a\t\r\n  b ", 1'b0);
        drain();
        check("delim_enable_pulses", WW'(en_rises - r0), WW'(2));
        check("delim_results", WW'(n_results - p0), WW'(2));
        check("delim_last_word", last_word, WW'(8'h62));

        // Truncation
        for (int i = 0; i < 40; i++) send_byte(8'h78, 1'b0);
        send_byte(8'h20, 1'b0);
        drain();
        check("trunc_word", last_word, {MAX_LEN{8'h78}});
        check("trunc_len", WW'(last_len), WW'(32));
        check("trunc_flag", WW'(last_trunc), WW'(1));
        send_str("ab ", 1'b0);
        drain();
        check("trunc_cleared", WW'(last_trunc), WW'(0));

        // Handshake: early ready ignored, slow engine, slow consumer
        idle_ready = 1'b1; eng_delay = 10; res_delay = 5;
        repeat (3) @(negedge clock);
        send_str("dog ", 1'b0);
        drain();
        check("hs_last_word", last_word, WW'(24'h646F67));
        idle_ready = 1'b0; res_delay = 0;

        // Randomised stream
        rand_eng = 1'b1; rand_res = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) send_byte(8'h61 + 8'($urandom_range(0, 25)), $urandom_range(0, 49) == 0);
            else if (r < 96) send_byte(dl[$urandom_range(0, 3)], $urandom_range(0, 49) == 0);
            else for (int k = 0; k < 34; k++) send_byte(8'h41 + 8'($urandom_range(0, 5)), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        send_byte(8'h20, 1'b0);
        drain();
        rand_eng = 1'b0; rand_res = 1'b0;

        // Reset while hashing
        eng_delay = 20;
        send_str("abc ", 1'b0);
        t = 0;
        while (!bus_if.eng_enable && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("mid_enable_seen", WW'(bus_if.eng_enable), WW'(1));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_eng_enable", WW'(bus_if.eng_enable), WW'(0));
        check("mid_res_valid", WW'(bus_if.res_valid), WW'(0));
        check("mid_counts", WW'({bus_if.word_count, bus_if.hit_count}), WW'(0));
        check("mid_eng_word", bus_if.eng_word, WW'(0));
        exp_res.delete(); exp_eng.delete(); cur.delete(); cur_trunc = 1'b0;
        m_words = 0; m_hits = 0;
        @(negedge clock);
        reset = 1'b0;
        eng_delay = 1;
        send_str("ok ", 1'b0);
        drain();
        check("post_reset_word", last_word, WW'(16'h6F6B));
        check("post_reset_present", WW'(last_present), WW'(1));
        check("post_reset_count", WW'(bus_if.word_count), WW'(1));

        // Counter saturation
        all_hit = 1'b1;
        wc0 = n_results;
        for (int w = 0; w < 20; w++) begin
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) send_byte(8'h61 + 8'($urandom_range(0, 25)), 1'b0);
            send_byte(8'h20, 1'b0);
        end
        drain();
        check("sat_results", WW'(n_results - wc0), WW'(20));
        check("sat_word_count", WW'(bus_if.word_count), WW'(15));
        check("sat_hit_count", WW'(bus_if.hit_count), WW'(15));
        check("enable_pulses_total", WW'(en_rises), WW'(n_words));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
